// File: rtl/grid_scan_ctrl_if.sv
// grid_scan_ctrl_if
//   Bundles the reader/game-FSM side signals of grid_scan_ctrl.
//   Inputs to the controller (driven by the master):
//     i_req        single-cycle capture request from the game FSM
//     i_H_Counter  VGA horizontal counter
//     i_V_Counter  VGA vertical counter
//     i_scan_done  reader done (level)
//     i_grid       reader result, 8x8 blocks x 4 bits, valid with i_scan_done
//   Outputs from the controller (driven by the slave):
//     o_scan_start one-cycle start pulse to the reader
//     o_busy       controller not idle
//     o_valid      one-cycle pulse, o_grid holds a new stable grid
//     o_timeout    one-cycle pulse, request failed
//     o_grid       last accepted stable grid
//     o_scan_cnt   captures performed for the current or last request
interface grid_scan_ctrl_if #(
    parameter int unsigned CNT_W = 13
);
    logic             i_req;
    logic [CNT_W-1:0] i_H_Counter;
    logic [CNT_W-1:0] i_V_Counter;
    logic             i_scan_done;
    logic [255:0]     i_grid;
    logic             o_scan_start;
    logic             o_busy;
    logic             o_valid;
    logic             o_timeout;
    logic [255:0]     o_grid;
    logic [7:0]       o_scan_cnt;

    modport master (
        output i_req, i_H_Counter, i_V_Counter, i_scan_done, i_grid,
        input  o_scan_start, o_busy, o_valid, o_timeout, o_grid, o_scan_cnt
    );

    modport slave (
        input  i_req, i_H_Counter, i_V_Counter, i_scan_done, i_grid,
        output o_scan_start, o_busy, o_valid, o_timeout, o_grid, o_scan_cnt
    );
endinterface

// File: rtl/grid_scan_ctrl.sv
// grid_scan_ctrl
//   Sequences the 8x8 grey-block averaging reader: on a request it arms the
//   reader at each frame boundary, collects one 256-bit grid per frame and
//   accepts a grid once STABLE_FRAMES consecutive captures are identical.
//   Gives up after MAX_SCANS captures or when the reader does not finish
//   within WDOG_CYCLES cycles.
// Ports:
//   i_Clk    system clock (VGA pixel clock domain)
//   i_rst_n  asynchronous active-low reset
//   bus      grid_scan_ctrl_if.slave (request, VGA counters, reader
//            handshake, result outputs)
// Build option:
//   GRID_SCAN_CONTINUOUS_EN  when defined, scanning repeats forever after the
//   first request and o_valid pulses only when the accepted grid changes.
module grid_scan_ctrl #(
    parameter int unsigned STABLE_FRAMES = 3,
    parameter int unsigned MAX_SCANS     = 16,
    parameter int unsigned WDOG_CYCLES   = 1200000,
    parameter int unsigned CNT_W         = 13
) (
    input logic            i_Clk,
    input logic            i_rst_n,
    grid_scan_ctrl_if.slave bus
);

    localparam int unsigned WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_FB = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_SCAN    = 3'd3;
    localparam logic [2:0] S_COMPARE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_FAIL    = 3'd6;

    logic [2:0]        state_q,     state_d;
    logic [7:0]        scan_cnt_q,  scan_cnt_d;
    logic [3:0]        match_cnt_q, match_cnt_d;
    logic [WDOG_W-1:0] wdog_q,      wdog_d;
    logic [255:0]      cur_grid_q,  cur_grid_d;
    logic [255:0]      prev_grid_q, prev_grid_d;
    logic [255:0]      grid_q,      grid_d;
    logic              valid_q,     valid_d;

    logic              fb;
    logic [3:0]        new_match;

    assign fb = (bus.i_V_Counter == CNT_W'(0)) && (bus.i_H_Counter == CNT_W'(0));

    always_comb begin
        state_d     = state_q;
        scan_cnt_d  = scan_cnt_q;
        match_cnt_d = match_cnt_q;
        wdog_d      = wdog_q;
        cur_grid_d  = cur_grid_q;
        prev_grid_d = prev_grid_q;
        grid_d      = grid_q;
        valid_d     = 1'b0;
        new_match   = 4'd1;

        case (state_q)
            S_IDLE: begin
                if (bus.i_req) begin
                    state_d     = S_WAIT_FB;
                    scan_cnt_d  = '0;
                    match_cnt_d = '0;
                end
            end
            S_WAIT_FB: begin
                if (fb) state_d = S_START;
            end
            S_START: begin
                scan_cnt_d = scan_cnt_q + 8'd1;
                wdog_d     = '0;
                state_d    = S_SCAN;
            end
            S_SCAN: begin
                // done takes priority over a simultaneous watchdog expiry
                if (bus.i_scan_done) begin
                    cur_grid_d = bus.i_grid;
                    state_d    = S_COMPARE;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = S_FAIL;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_COMPARE: begin
                if (scan_cnt_q == 8'd1 || cur_grid_q != prev_grid_q)
                    new_match = 4'd1;
                else if (match_cnt_q == 4'd15)
                    new_match = 4'd15;
                else
                    new_match = match_cnt_q + 4'd1;
                match_cnt_d = new_match;
                prev_grid_d = cur_grid_q;
                // o_grid/o_valid are loaded here so they appear together in DONE
                if (new_match == 4'(STABLE_FRAMES)) begin
                    state_d = S_DONE;
                    grid_d  = cur_grid_q;
`ifdef GRID_SCAN_CONTINUOUS_EN
                    valid_d = (cur_grid_q != grid_q);
`else
                    valid_d = 1'b1;
`endif
                end else if (scan_cnt_q == 8'(MAX_SCANS)) begin
                    state_d = S_FAIL;
                end else begin
                    state_d = S_WAIT_FB;
                end
            end
            S_DONE, S_FAIL: begin
`ifdef GRID_SCAN_CONTINUOUS_EN
                state_d     = S_WAIT_FB;
                scan_cnt_d  = '0;
                match_cnt_d = '0;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            scan_cnt_q  <= '0;
            match_cnt_q <= '0;
            wdog_q      <= '0;
            cur_grid_q  <= '0;
            prev_grid_q <= '0;
            grid_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            scan_cnt_q  <= scan_cnt_d;
            match_cnt_q <= match_cnt_d;
            wdog_q      <= wdog_d;
            cur_grid_q  <= cur_grid_d;
            prev_grid_q <= prev_grid_d;
            grid_q      <= grid_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.o_scan_start = (state_q == S_START);
    assign bus.o_busy       = (state_q != S_IDLE);
    assign bus.o_valid      = valid_q;
    assign bus.o_timeout    = (state_q == S_FAIL);
    assign bus.o_grid       = grid_q;
    assign bus.o_scan_cnt   = scan_cnt_q;

endmodule

// File: tb/tb_grid_scan_ctrl.sv
module tb_grid_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    grid_scan_ctrl_if #(.CNT_W(13)) bus ();

    grid_scan_ctrl #(
        .STABLE_FRAMES(3),
        .MAX_SCANS    (6),
        .WDOG_CYCLES  (1000),
        .CNT_W        (13)
    ) dut (
        .i_Clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit           is_valid;
        logic [255:0] grid;
        logic [7:0]   cnt;
        int           cyc;
    } ev_t;

    ev_t evq[$];
    int  startq[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    logic [255:0] G1, A, B, C;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops expected start pulses and result events as the DUT shows them
    always @(negedge clk) begin
        ev_t e;
        int  s;
        if (rst_n) begin
            if (bus.o_scan_start) begin
                if (startq.size() == 0) check("unexpected_start", bus.o_scan_start, 0);
                else begin
                    s = startq.pop_front();
                    check("start_cycle", cyc, s);
                end
            end
            if (bus.o_valid || bus.o_timeout) begin
                check("valid_timeout_exclusive", bus.o_valid & bus.o_timeout, 0);
                if (evq.size() == 0) check("unexpected_event", {bus.o_valid, bus.o_timeout}, 0);
                else begin
                    e = evq.pop_front();
                    check("event_kind_valid", bus.o_valid, e.is_valid);
                    check("event_cycle", cyc, e.cyc);
                    check("o_grid", bus.o_grid, e.grid);
                    check("o_scan_cnt", bus.o_scan_cnt, e.cnt);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_counters();
        bus.i_H_Counter = 13'd7;
        bus.i_V_Counter = 13'd3;
    endtask

    task automatic request();
        bus.i_req = 1'b1;
        step();
        bus.i_req = 1'b0;
        check("busy_after_req", bus.o_busy, 1);
    endtask

    // Drive fb; the DUT is expected to start one cycle later.
    task automatic frame_boundary(input bit expect_start);
        bus.i_H_Counter = '0;
        bus.i_V_Counter = '0;
        if (expect_start) startq.push_back(cyc + 1);
        step();
        idle_counters();
    endtask

    // One frame: near-miss counters, fb, a done during START (must be
    // ignored), then the real done d cycles into SCAN.
    task automatic capture(input logic [255:0] g, input int d, output int done_cyc);
        step(2);
        bus.i_H_Counter = '0;    bus.i_V_Counter = 13'd5; step();
        bus.i_H_Counter = 13'd9; bus.i_V_Counter = '0;    step();
        frame_boundary(1'b1);
        bus.i_scan_done = 1'b1;
        bus.i_grid      = ~g;
        step();
        bus.i_scan_done = 1'b0;
        step(d);
        bus.i_scan_done = 1'b1;
        bus.i_grid      = g;
        done_cyc        = cyc;
        step();
        bus.i_scan_done = 1'b0;
        bus.i_grid      = '0;
    endtask

    task automatic push_ev(input bit v, input logic [255:0] g, input logic [7:0] n, input int at);
        ev_t e;
        e.is_valid = v;
        e.grid     = g;
        e.cnt      = n;
        e.cyc      = at;
        evq.push_back(e);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((evq.size() != 0 || startq.size() != 0) && k < 50) begin
            step();
            k++;
        end
        step(2);
        check({name, "_pending"}, evq.size() + startq.size(), 0);
        check({name, "_idle"}, bus.o_busy, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"},  bus.o_busy, 0);
        check({name, "_start"}, bus.o_scan_start, 0);
        check({name, "_valid"}, bus.o_valid, 0);
        check({name, "_tmo"},   bus.o_timeout, 0);
        check({name, "_grid"},  bus.o_grid, 0);
        check({name, "_cnt"},   bus.o_scan_cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int dc;
        G1 = {64{4'h1}};
        A  = {64{4'hA}};
        B  = A ^ 256'h1;
        C  = {32{8'h3C}};

        rst_n           = 1'b0;
        bus.i_req       = 1'b1;
        bus.i_scan_done = 1'b0;
        bus.i_grid      = '0;
        bus.i_H_Counter = '0;
        bus.i_V_Counter = '0;

        // Reset held with request and fb asserted
        for (int i = 0; i < 3; i++) begin
            step();
            check_reset_outputs("reset");
        end
        bus.i_req = 1'b0;
        idle_counters();
        rst_n = 1'b1;
        step(2);
        frame_boundary(1'b0);
        step(3);
        frame_boundary(1'b0);
        step(2);
        check("post_reset_idle", bus.o_busy, 0);

        // Stable capture; an extra request while busy is ignored
        request();
        capture(G1, 0, dc);
        bus.i_req = 1'b1; step(); bus.i_req = 1'b0;
        capture(G1, 4, dc);
        capture(G1, 1, dc);
        push_ev(1'b1, G1, 8'd3, dc + 2);
        drain("stable");
        frame_boundary(1'b0);
        step(3);
        check("req_not_queued", bus.o_busy, 0);

        // Instability A,B,B,A,A,A; acceptance coincides with MAX_SCANS
        request();
        capture(A, 0, dc);
        capture(B, 2, dc);
        capture(B, 0, dc);
        capture(A, 3, dc);
        capture(A, 0, dc);
        capture(A, 1, dc);
        push_ev(1'b1, A, 8'd6, dc + 2);
        drain("unstable");

        // Exhaustion: alternating grids, o_grid keeps A
        request();
        for (int i = 0; i < 6; i++) capture((i % 2 == 0) ? B : C, i, dc);
        push_ev(1'b0, A, 8'd6, dc + 2);
        drain("exhaust");

        // Watchdog: no done, timeout 1000 cycles after SCAN entry
        request();
        step(2);
        begin
            int fbc;
            fbc = cyc;
            frame_boundary(1'b1);
            push_ev(1'b0, A, 8'd1, fbc + 2 + 1000);
        end
        step(1005);
        drain("watchdog");

        // Done on the last watchdog cycle wins; then a stable C
        request();
        capture(C, 999, dc);
        capture(C, 0, dc);
        capture(C, 0, dc);
        push_ev(1'b1, C, 8'd3, dc + 2);
        drain("wdog_edge");

        // Reset during SCAN aborts with no result
        request();
        step(2);
        frame_boundary(1'b1);
        step(5);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        step(2);
        rst_n = 1'b1;
        step(2);
        bus.i_scan_done = 1'b1; bus.i_grid = C; step(); bus.i_scan_done = 1'b0;
        frame_boundary(1'b0);
        step(5);
        drain("abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
